// File: rtl/hart_arb_pkg.sv
// Shared types for the N-hart memory arbiter: FSM encoding, reservation entry
// and the address-to-granule helper.
package hart_arb_pkg;

    localparam int MAX_AW = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] granule;
    } resv_t;

    // Granules are compared zero-extended to MAX_AW so one entry type fits any AW.
    function automatic logic [MAX_AW-1:0] granule_of(input logic [MAX_AW-1:0] addr,
                                                      input int unsigned       shift);
        return addr >> shift;
    endfunction

endpackage

// File: rtl/hart_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// returned both one-hot and as an index.
module hart_arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          hit
);

    always_comb begin : pick
        logic [IW-1:0] j;
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        j     = '0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(last) + i) % N);
            if (!hit && req[j]) begin
                hit      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/hart_mem_arbiter.sv
// N-hart shared-memory arbiter with LR/SC reservation tracking.
// Define HART_ARB_LOCK_EN to let an owner hold the grant across an atomic sequence.
//
// state   | meaning
// S_IDLE  | pick next requester (locked owner first), latch its request
// S_ISSUE | one-cycle memory strobe, or skip straight to DONE on a failed SC
// S_WAIT  | wait for m_busy to fall, capture load data
// S_DONE  | pulse o_done, update reservations and round-robin pointer
module hart_mem_arbiter
    import hart_arb_pkg::*;
#(
    parameter int NHARTS     = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RESV_SHIFT = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NHARTS-1:0]    i_req,
    input  logic [NHARTS*AW-1:0] i_addr,
    input  logic [NHARTS*DW-1:0] i_wdata,
    input  logic [NHARTS-1:0]    i_we,
    input  logic [NHARTS-1:0]    i_lr,
    input  logic [NHARTS-1:0]    i_sc,
    input  logic [NHARTS-1:0]    i_lock,
    output logic [NHARTS-1:0]    o_grant,
    output logic [NHARTS-1:0]    o_done,
    output logic [DW-1:0]        o_rdata,
    output logic [NHARTS-1:0]    o_sc_fail,
    output logic [NHARTS-1:0]    o_reserved,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_wdata,
    output logic                 m_we,
    output logic                 m_le,
    input  logic                 m_busy,
    input  logic [DW-1:0]        m_rdata
);

    localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    state_t            state, state_nxt;
    logic [NHARTS-1:0] grant_r, pick_grant, sel_grant;
    logic [IW-1:0]     owner, last, pick_idx, sel_idx;
    logic              pick_hit, take, keep_grant, lock_drop;
    logic [AW-1:0]     lat_addr;
    logic [DW-1:0]     lat_wdata, rdata_r;
    logic              lat_we, lat_lr, lat_sc, sc_fail_r, sc_reject;
    logic [MAX_AW-1:0] lat_gran;
    logic [NHARTS-1:0] resv_valid;
    logic [MAX_AW-1:0] resv_gran [NHARTS];
    logic [AW-1:0]     addr_a    [NHARTS];
    logic [DW-1:0]     wdata_a   [NHARTS];

    for (genvar k = 0; k < NHARTS; k++) begin : g_split
        assign addr_a[k]  = i_addr[k*AW +: AW];
        assign wdata_a[k] = i_wdata[k*DW +: DW];
    end

    hart_arb_rr_pick #(.N(NHARTS), .IW(IW)) u_pick (
        .req   (i_req),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .hit   (pick_hit)
    );

`ifdef HART_ARB_LOCK_EN
    logic locked;

    assign take       = locked ? i_req[owner] : pick_hit;
    assign sel_idx    = locked ? owner : pick_idx;
    assign sel_grant  = locked ? grant_r : pick_grant;
    assign keep_grant = i_lock[owner];
    assign lock_drop  = locked && !i_req[owner];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            locked <= 1'b0;
        else if (state == S_DONE)
            locked <= i_lock[owner];
        else if (state == S_IDLE && lock_drop)
            locked <= 1'b0;
    end
`else
    logic unused_lock;

    assign take        = pick_hit;
    assign sel_idx     = pick_idx;
    assign sel_grant   = pick_grant;
    assign keep_grant  = 1'b0;
    assign lock_drop   = 1'b0;
    assign unused_lock = ^i_lock;
`endif

    assign lat_gran  = granule_of(MAX_AW'(lat_addr), RESV_SHIFT);
    assign sc_reject = lat_sc && !(resv_valid[owner] && resv_gran[owner] == lat_gran);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_we      = 1'b0;
        m_le      = 1'b0;
        o_done    = '0;
        o_sc_fail = '0;
        case (state)
            S_IDLE:  if (take) state_nxt = S_ISSUE;
            S_ISSUE: begin
                state_nxt = sc_reject ? S_DONE : S_WAIT;
                m_we      = lat_we && !sc_reject;
                m_le      = !lat_we;
            end
            S_WAIT:  if (!m_busy) state_nxt = S_DONE;
            S_DONE: begin
                state_nxt = S_IDLE;
                o_done    = grant_r;
                o_sc_fail = sc_fail_r ? grant_r : '0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_r   <= '0;
            owner     <= '0;
            last      <= IW'(NHARTS - 1);
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_lr    <= 1'b0;
            lat_sc    <= 1'b0;
            sc_fail_r <= 1'b0;
            rdata_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lock_drop) begin
                        grant_r <= '0;
                    end else if (take) begin
                        grant_r   <= sel_grant;
                        owner     <= sel_idx;
                        lat_addr  <= addr_a[sel_idx];
                        lat_wdata <= wdata_a[sel_idx];
                        lat_we    <= i_we[sel_idx];
                        lat_lr    <= i_lr[sel_idx] & ~i_we[sel_idx];
                        lat_sc    <= i_sc[sel_idx] & i_we[sel_idx];
                        sc_fail_r <= 1'b0;
                    end
                end
                S_ISSUE: sc_fail_r <= sc_reject;
                S_WAIT:  if (!m_busy && !lat_we) rdata_r <= m_rdata;
                S_DONE: begin
                    last <= owner;
                    if (!keep_grant) grant_r <= '0;
                end
                default: ;
            endcase
        end
    end

    // Own plain stores keep the owner's reservation; only other harts lose theirs.
    for (genvar k = 0; k < NHARTS; k++) begin : g_resv
        resv_t entry;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                entry <= '0;
            end else if (state == S_DONE) begin
                if (owner == IW'(k)) begin
                    if (lat_lr)
                        entry <= '{valid: 1'b1, granule: lat_gran};
                    else if (lat_sc)
                        entry.valid <= 1'b0;
                end else if (lat_we && !sc_fail_r && entry.granule == lat_gran) begin
                    entry.valid <= 1'b0;
                end
            end
        end

        assign resv_valid[k] = entry.valid;
        assign resv_gran[k]  = entry.granule;
    end

    assign o_reserved = resv_valid;
    assign o_grant    = grant_r;
    assign o_rdata    = rdata_r;
    assign m_addr     = lat_addr;
    assign m_wdata    = lat_wdata;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed bench for hart_mem_arbiter (4 harts) with a busy-counting memory model.
// The lock sequence runs only when HART_ARB_LOCK_EN is defined.
module tb_hart_mem_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  i_req = '0, i_we = '0, i_lr = '0, i_sc = '0, i_lock = '0;
    logic [N*32-1:0] i_addr = '0, i_wdata = '0;
    logic [N-1:0]  o_grant, o_done, o_sc_fail, o_reserved;
    logic [31:0]   o_rdata, m_addr, m_wdata;
    logic          m_we, m_le;
    logic          m_busy;
    logic [31:0]   m_rdata = '0;

    int busy_len = 1;
    int busy_cnt;
    int we_cnt = 0, le_cnt = 0;
    logic [31:0] last_wdata = '0, last_waddr = '0;
    int n_chk = 0, n_err = 0;

    hart_mem_arbiter #(.NHARTS(N), .AW(32), .DW(32), .RESV_SHIFT(2)) dut (
        .CLK(clk), .RST(rst),
        .i_req(i_req), .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we),
        .i_lr(i_lr), .i_sc(i_sc), .i_lock(i_lock),
        .o_grant(o_grant), .o_done(o_done), .o_rdata(o_rdata),
        .o_sc_fail(o_sc_fail), .o_reserved(o_reserved),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_le(m_le),
        .m_busy(m_busy), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            busy_cnt <= 0;
        end else if (m_we || m_le) begin
            m_busy   <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            m_busy   <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (m_le) le_cnt <= le_cnt + 1;
        if (m_we) begin
            we_cnt     <= we_cnt + 1;
            last_wdata <= m_wdata;
            last_waddr <= m_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_hart(input int h, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic lr, input logic sc);
        i_addr[h*32 +: 32]  = addr;
        i_wdata[h*32 +: 32] = wdata;
        i_we[h] = we;
        i_lr[h] = lr;
        i_sc[h] = sc;
        i_req[h] = 1'b1;
    endtask

    task automatic drop_hart(input int h);
        i_req[h] = 1'b0;
        i_we[h]  = 1'b0;
        i_lr[h]  = 1'b0;
        i_sc[h]  = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle.
    task automatic wait_done(output logic [N-1:0] d, output int lat);
        bit found = 0;
        d = '0;
        lat = 0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            lat++;
            if (o_done != '0) begin
                found = 1;
                d = o_done;
            end
        end
        chk("done_seen", 64'(found), 64'd1);
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge after DONE.
    task automatic run_txn(input int h, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic lr, input logic sc,
                           output logic sc_f, output logic [31:0] rd, output int lat);
        logic [N-1:0] d;
        set_hart(h, addr, wdata, we, lr, sc);
        wait_done(d, lat);
        chk("done_owner", d, 64'(1 << h));
        sc_f = o_sc_fail[h];
        rd   = o_rdata;
        drop_hart(h);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] d;
        logic         sc_f;
        logic [31:0]  rd;
        int           lat, we0, le0;

        // Reset state and first load
        @(negedge clk);
        chk("rst_grant", o_grant, 0);
        chk("rst_reserved", o_reserved, 0);
        chk("rst_strobes", {m_we, m_le, o_done}, 0);
        apply_reset();
        busy_len = 3;
        m_rdata  = 32'hDEADBEEF;
        le0 = le_cnt;
        set_hart(0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_grant_lat", o_grant, 4'b0001);
        chk("t1_m_le", m_le, 1);
        chk("t1_m_addr", m_addr, 32'h8000_0010);
        wait_done(d, lat);
        chk("t1_done", d, 4'b0001);
        chk("t1_rdata", o_rdata, 32'hDEADBEEF);
        drop_hart(0);
        @(negedge clk);
        chk("t1_le_pulses", le_cnt - le0, 1);
        chk("t1_idle_grant", o_grant, 0);

        // Round robin with all four harts requesting continuously
        apply_reset();
        busy_len = 1;
        for (int h = 0; h < N; h++) set_hart(h, 32'h100 * h, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            wait_done(d, lat);
            chk("rr_order", d, 64'(1 << (n % N)));
            chk("rr_grant", o_grant, 64'(1 << (n % N)));
        end
        for (int h = 0; h < N; h++) drop_hart(h);
        @(negedge clk);

        // LR then conflicting store kills the reservation; SC fails with no write
        run_txn(0, 32'h1000, 0, 1'b0, 1'b1, 1'b0, sc_f, rd, lat);
        chk("lr_min_latency", lat, 4);
        chk("lr_reserved", o_reserved, 4'b0001);
        run_txn(1, 32'h1000, 32'h11, 1'b1, 1'b0, 1'b0, sc_f, rd, lat);
        chk("store_clears", o_reserved, 4'b0000);
        we0 = we_cnt;
        run_txn(0, 32'h1000, 32'h7, 1'b1, 1'b0, 1'b1, sc_f, rd, lat);
        chk("sc_fail", sc_f, 1);
        chk("sc_fail_no_we", we_cnt - we0, 0);

        // Non-conflicting store leaves reservation; SC succeeds
        run_txn(0, 32'h1000, 0, 1'b0, 1'b1, 1'b0, sc_f, rd, lat);
        run_txn(1, 32'h1008, 32'h22, 1'b1, 1'b0, 1'b0, sc_f, rd, lat);
        chk("other_granule_keeps", o_reserved, 4'b0001);
        we0 = we_cnt;
        run_txn(0, 32'h1000, 32'h5, 1'b1, 1'b0, 1'b1, sc_f, rd, lat);
        chk("sc_ok", sc_f, 0);
        chk("sc_ok_we", we_cnt - we0, 1);
        chk("sc_ok_wdata", last_wdata, 32'h5);
        chk("sc_ok_waddr", last_waddr, 32'h1000);
        chk("sc_ok_resv", o_reserved, 4'b0000);

        // Own plain store keeps own reservation; same granule, different byte clears others
        run_txn(1, 32'h2000, 0, 1'b0, 1'b1, 1'b0, sc_f, rd, lat);
        run_txn(1, 32'h2000, 32'h33, 1'b1, 1'b0, 1'b0, sc_f, rd, lat);
        chk("own_store_keeps", o_reserved, 4'b0010);
        run_txn(0, 32'h3000, 0, 1'b0, 1'b1, 1'b0, sc_f, rd, lat);
        chk("two_reserved", o_reserved, 4'b0011);
        run_txn(1, 32'h3002, 32'h44, 1'b1, 1'b0, 1'b0, sc_f, rd, lat);
        chk("granule_match_clears", o_reserved, 4'b0010);

        // Reset in the middle of a store's WAIT
        run_txn(0, 32'h1000, 0, 1'b0, 1'b1, 1'b0, sc_f, rd, lat);
        busy_len = 5;
        set_hart(1, 32'h4000, 32'h55, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_grant", o_grant, 4'b0010);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {o_grant, o_done, o_sc_fail, o_reserved, m_we, m_le}, 0);
        chk("rst_mid_data", {m_addr, m_wdata}, 0);
        chk("rst_mid_rdata", o_rdata, 0);
        drop_hart(1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy_len = 1;
        set_hart(0, 32'h10, 0, 1'b0, 1'b0, 1'b0);
        set_hart(1, 32'h20, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_first", o_grant, 4'b0001);
        wait_done(d, lat);
        chk("post_rst_done0", d, 4'b0001);
        drop_hart(0);
        wait_done(d, lat);
        chk("post_rst_done1", d, 4'b0010);
        drop_hart(1);
        @(negedge clk);

`ifdef HART_ARB_LOCK_EN
        // Hart1 holds the bus for two transactions while hart0 waits
        i_lock[1] = 1'b1;
        set_hart(1, 32'h5000, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lock_grant", o_grant, 4'b0010);
        set_hart(0, 32'h6000, 0, 1'b0, 1'b0, 1'b0);
        wait_done(d, lat);
        chk("lock_first", d, 4'b0010);
        @(negedge clk);
        chk("lock_hold_grant", o_grant, 4'b0010);
        i_lock[1] = 1'b0;
        wait_done(d, lat);
        chk("lock_second", d, 4'b0010);
        drop_hart(1);
        wait_done(d, lat);
        chk("lock_release", d, 4'b0001);
        drop_hart(0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
